// File: rtl/layer4_fc_sched.sv
// Layer 4 FC sequencer: splits the weight stream into bias + per-beat weight vectors and pairs them with activations.
// Optional next-vector weight prefetch during ISSUE is enabled by defining LAYER4_SCHED_PREFETCH_EN.
module layer4_fc_sched #(
  parameter int unsigned N_OUT  = 10,
  parameter int unsigned W_W    = 16,
  parameter int unsigned IN_LEN = 192
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  input  logic [W_W-1:0]         fc_weight_TDATA,
  input  logic                   fc_weight_TVALID,
  output logic                   fc_weight_TREADY,
  input  logic [31:0]            a_Data_TDATA,
  input  logic                   a_Data_TVALID,
  output logic                   a_Data_TREADY,
  output logic [31:0]            fc_a_TDATA,
  output logic [N_OUT*W_W-1:0]   fc_w_TDATA,
  output logic                   fc_TVALID,
  input  logic                   fc_TREADY,
  output logic                   fc_TLAST,
  output logic [N_OUT*W_W-1:0]   bias_data,
  output logic                   bias_valid,
  input  logic                   label_done
);

  localparam int unsigned WCNT_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int unsigned ICNT_W = (IN_LEN > 1) ? $clog2(IN_LEN + 1) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(N_OUT - 1);
  localparam logic [ICNT_W-1:0] ICNT_LAST = ICNT_W'(IN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_WGATH,
    S_ISSUE,
    S_WAIT_LBL
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [WCNT_W-1:0]      r_wcnt;
  logic [ICNT_W-1:0]      r_in_cnt;
  logic [W_W-1:0]         r_bias [N_OUT];
  logic [W_W-1:0]         r_gath [N_OUT];
  logic [N_OUT*W_W-1:0]   r_fc_w;
  logic                   r_bias_valid;
  logic                   r_done;
  logic                   w_wt_rdy;
  logic                   w_wt_hs;
  logic                   w_xfer;
  logic                   w_last;
  logic                   w_pf_rdy;
  logic                   w_pf_full;

  assign w_last   = (r_in_cnt == ICNT_LAST);
  assign w_xfer   = (r_state == S_ISSUE) && a_Data_TVALID && fc_TREADY;
  assign w_wt_rdy = (r_state == S_BIAS) || (r_state == S_WGATH) ||
                    ((r_state == S_ISSUE) && w_pf_rdy);
  assign w_wt_hs  = fc_weight_TVALID && w_wt_rdy;

`ifdef LAYER4_SCHED_PREFETCH_EN
  localparam int unsigned PCNT_W = $clog2(N_OUT + 1);

  logic [W_W-1:0]    r_pf [N_OUT];
  logic [PCNT_W-1:0] r_pcnt;
  logic [PCNT_W-1:0] w_pf_fill;
  logic [W_W-1:0]    w_pf_merged [N_OUT];
  logic              w_pf_hs;

  // Never fetch past the last beat of the frame.
  assign w_pf_rdy  = (r_pcnt < PCNT_W'(N_OUT)) && !w_last;
  assign w_pf_hs   = (r_state == S_ISSUE) && w_wt_hs;
  assign w_pf_fill = r_pcnt + PCNT_W'(w_pf_hs);
  assign w_pf_full = (w_pf_fill == PCNT_W'(N_OUT));

  // Prefetch buffer with the word arriving this cycle folded in.
  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      w_pf_merged[k] = (w_pf_hs && (r_pcnt == PCNT_W'(k))) ? fc_weight_TDATA : r_pf[k];
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_pcnt <= '0;
      for (int k = 0; k < N_OUT; k++) r_pf[k] <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_pcnt <= '0;
    end else if (w_xfer) begin
      r_pcnt <= '0;
    end else if (w_pf_hs) begin
      r_pf[WCNT_W'(r_pcnt)] <= fc_weight_TDATA;
      r_pcnt                <= r_pcnt + PCNT_W'(1);
    end
  end
`else
  assign w_pf_rdy  = 1'b0;
  assign w_pf_full = 1'b0;
`endif

  always_ff @(posedge ap_clk) begin
    if (ap_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    busy          = (r_state != S_IDLE);
    fc_TVALID     = 1'b0;
    fc_TLAST      = 1'b0;
    a_Data_TREADY = 1'b0;
    case (r_state)
      S_IDLE:     if (start) w_state_nxt = S_BIAS;
      S_BIAS:     if (w_wt_hs && (r_wcnt == WCNT_LAST)) w_state_nxt = S_WGATH;
      S_WGATH:    if (w_wt_hs && (r_wcnt == WCNT_LAST)) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        fc_TVALID     = a_Data_TVALID;
        a_Data_TREADY = fc_TREADY;
        fc_TLAST      = w_last;
        if (w_xfer) begin
          if (w_last)          w_state_nxt = S_WAIT_LBL;
          else if (!w_pf_full) w_state_nxt = S_WGATH;
        end
      end
      S_WAIT_LBL: if (label_done) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Counters, bias capture, vector gather and issue register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_wcnt       <= '0;
      r_in_cnt     <= '0;
      r_fc_w       <= '0;
      r_bias_valid <= 1'b0;
      r_done       <= 1'b0;
      for (int k = 0; k < N_OUT; k++) begin
        r_bias[k] <= '0;
        r_gath[k] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bias_valid <= 1'b0;
            r_wcnt       <= '0;
            r_in_cnt     <= '0;
          end
        end
        S_BIAS: begin
          if (w_wt_hs) begin
            r_bias[r_wcnt] <= fc_weight_TDATA;
            if (r_wcnt == WCNT_LAST) begin
              r_wcnt       <= '0;
              r_bias_valid <= 1'b1;
            end else begin
              r_wcnt <= r_wcnt + WCNT_W'(1);
            end
          end
        end
        S_WGATH: begin
          if (w_wt_hs) begin
            r_gath[r_wcnt] <= fc_weight_TDATA;
            if (r_wcnt == WCNT_LAST) begin
              r_wcnt <= '0;
              for (int k = 0; k < N_OUT; k++) begin
                r_fc_w[k*W_W +: W_W] <= (k == int'(N_OUT - 1)) ? fc_weight_TDATA : r_gath[k];
              end
            end else begin
              r_wcnt <= r_wcnt + WCNT_W'(1);
            end
          end
        end
        S_ISSUE: begin
          if (w_xfer) begin
            if (w_last) begin
              r_in_cnt <= '0;
            end else begin
              r_in_cnt <= r_in_cnt + ICNT_W'(1);
`ifdef LAYER4_SCHED_PREFETCH_EN
              // Full buffer issues straight away; a partial one seeds the gather.
              if (w_pf_full) begin
                for (int k = 0; k < N_OUT; k++) r_fc_w[k*W_W +: W_W] <= w_pf_merged[k];
              end else begin
                for (int k = 0; k < N_OUT; k++) r_gath[k] <= w_pf_merged[k];
                r_wcnt <= WCNT_W'(w_pf_fill);
              end
`endif
            end
          end
        end
        S_WAIT_LBL: if (label_done) r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_bias
    assign bias_data[k*W_W +: W_W] = r_bias[k];
  end

  assign fc_weight_TREADY = w_wt_rdy;
  assign fc_a_TDATA       = a_Data_TDATA;
  assign fc_w_TDATA       = r_fc_w;
  assign bias_valid       = r_bias_valid;
  assign done             = r_done;

endmodule

// File: tb/tb_layer4_fc_sched.sv
// Scoreboard bench for layer4_fc_sched (N_OUT=10, IN_LEN=4); honours LAYER4_SCHED_PREFETCH_EN.
module tb_layer4_fc_sched;

  localparam int unsigned N_OUT  = 10;
  localparam int unsigned W_W    = 16;
  localparam int unsigned IN_LEN = 4;
  localparam int unsigned VW     = N_OUT * W_W;
  localparam int unsigned CW     = 160;
`ifdef LAYER4_SCHED_PREFETCH_EN
  localparam int unsigned EXP_GAP = N_OUT;
`else
  localparam int unsigned EXP_GAP = N_OUT + 1;
`endif

  logic            ap_clk;
  logic            ap_rst;
  logic            start;
  logic            busy;
  logic            done;
  logic [W_W-1:0]  fc_weight_TDATA;
  logic            fc_weight_TVALID;
  logic            fc_weight_TREADY;
  logic [31:0]     a_Data_TDATA;
  logic            a_Data_TVALID;
  logic            a_Data_TREADY;
  logic [31:0]     fc_a_TDATA;
  logic [VW-1:0]   fc_w_TDATA;
  logic            fc_TVALID;
  logic            fc_TREADY;
  logic            fc_TLAST;
  logic [VW-1:0]   bias_data;
  logic            bias_valid;
  logic            label_done;

  layer4_fc_sched #(.N_OUT(N_OUT), .W_W(W_W), .IN_LEN(IN_LEN)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .start(start), .busy(busy), .done(done),
    .fc_weight_TDATA(fc_weight_TDATA), .fc_weight_TVALID(fc_weight_TVALID),
    .fc_weight_TREADY(fc_weight_TREADY),
    .a_Data_TDATA(a_Data_TDATA), .a_Data_TVALID(a_Data_TVALID), .a_Data_TREADY(a_Data_TREADY),
    .fc_a_TDATA(fc_a_TDATA), .fc_w_TDATA(fc_w_TDATA), .fc_TVALID(fc_TVALID),
    .fc_TREADY(fc_TREADY), .fc_TLAST(fc_TLAST),
    .bias_data(bias_data), .bias_valid(bias_valid), .label_done(label_done)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic [VW-1:0] w;
    logic [31:0]   a;
    logic          last;
  } beat_t;

  beat_t          sb[$];
  logic [W_W-1:0] wq[$];
  logic [31:0]    aq[$];
  logic [W_W-1:0] exp_bias [N_OUT];

  int n_checks   = 0;
  int n_errors   = 0;
  int cyc        = 0;
  int done_cnt   = 0;
  int last_cyc   = -1;
  bit spacing_en = 1'b0;
  bit w_toggle   = 1'b0;
  bit flush      = 1'b0;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge ap_clk) cyc <= cyc + 1;

  // Weight stream driver: pops on handshake, optional every-other-cycle valid.
  initial begin : wdrv
    bit hs;
    bit tog;
    logic [W_W-1:0] d;
    tog = 1'b0;
    fc_weight_TVALID = 1'b0;
    fc_weight_TDATA  = '0;
    forever begin
      @(negedge ap_clk); #1;
      hs = fc_weight_TVALID && fc_weight_TREADY;
      @(posedge ap_clk); #1;
      if (flush) wq.delete();
      else if (hs) d = wq.pop_front();
      tog = !tog;
      if (wq.size() > 0 && !(w_toggle && tog)) begin
        fc_weight_TVALID = 1'b1;
        fc_weight_TDATA  = wq[0];
      end else begin
        fc_weight_TVALID = 1'b0;
        fc_weight_TDATA  = '0;
      end
    end
  end

  initial begin : adrv
    bit hs;
    logic [31:0] d;
    a_Data_TVALID = 1'b0;
    a_Data_TDATA  = '0;
    forever begin
      @(negedge ap_clk); #1;
      hs = a_Data_TVALID && a_Data_TREADY;
      @(posedge ap_clk); #1;
      if (flush) aq.delete();
      else if (hs) d = aq.pop_front();
      if (aq.size() > 0) begin
        a_Data_TVALID = 1'b1;
        a_Data_TDATA  = aq[0];
      end else begin
        a_Data_TVALID = 1'b0;
        a_Data_TDATA  = '0;
      end
    end
  end

  // Monitor: scoreboard compare on each joint beat, stall stability, beat spacing, done count.
  initial begin : mon
    beat_t e;
    bit prev_stall;
    logic [VW-1:0] prev_w;
    logic [31:0] prev_a;
    logic prev_last;
    prev_stall = 1'b0;
    forever begin
      @(negedge ap_clk); #1;
      if (prev_stall) begin
        check("stall_valid", CW'(fc_TVALID), CW'(1));
        check("stall_w", CW'(fc_w_TDATA), CW'(prev_w));
        check("stall_a", CW'(fc_a_TDATA), CW'(prev_a));
        check("stall_last", CW'(fc_TLAST), CW'(prev_last));
      end
`ifdef LAYER4_SCHED_PREFETCH_EN
      if (fc_TVALID && fc_TLAST) check("last_issue_wrdy", CW'(fc_weight_TREADY), CW'(0));
`else
      if (fc_TVALID) check("issue_wrdy", CW'(fc_weight_TREADY), CW'(0));
`endif
      if (fc_TVALID && fc_TREADY) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", CW'(1), CW'(0));
        end else begin
          e = sb.pop_front();
          check("beat_w", CW'(fc_w_TDATA), CW'(e.w));
          check("beat_a", CW'(fc_a_TDATA), CW'(e.a));
          check("beat_last", CW'(fc_TLAST), CW'(e.last));
        end
        if (spacing_en && last_cyc >= 0) check("beat_gap", CW'(cyc - last_cyc), CW'(EXP_GAP));
        last_cyc = cyc;
      end
      prev_stall = fc_TVALID && !fc_TREADY;
      prev_w     = fc_w_TDATA;
      prev_a     = fc_a_TDATA;
      prev_last  = fc_TLAST;
      if (done) done_cnt++;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, CW'({busy, done, bias_valid, fc_TVALID, fc_TLAST,
                              fc_weight_TREADY, a_Data_TREADY}), CW'(0));
    check({tag, "_fcw"}, CW'(fc_w_TDATA), CW'(0));
    check({tag, "_bias"}, CW'(bias_data), CW'(0));
  endtask

  task automatic load_frame(input int fid);
    logic [VW-1:0]  vec;
    logic [W_W-1:0] ww;
    logic [31:0]    a;
    beat_t          e;
    for (int k = 0; k < N_OUT; k++) begin
      exp_bias[k] = W_W'(k + 1) + W_W'(fid * 32);
      wq.push_back(exp_bias[k]);
    end
    for (int b = 0; b < IN_LEN; b++) begin
      vec = '0;
      for (int k = 0; k < N_OUT; k++) begin
        ww = W_W'(16'h0100) + W_W'(b * N_OUT + k) + W_W'(fid << 12);
        wq.push_back(ww);
        vec[k*W_W +: W_W] = ww;
      end
      a = $urandom;
      aq.push_back(a);
      e.w = vec;
      e.a = a;
      e.last = (b == IN_LEN - 1);
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start();
    @(negedge ap_clk);
    start = 1'b1;
    last_cyc = -1;
    @(negedge ap_clk);
    start = 1'b0;
    check("start_busy", CW'(busy), CW'(1));
    check("start_bvalid_clr", CW'(bias_valid), CW'(0));
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!fc_TVALID && t < 500) begin
      @(negedge ap_clk);
      t++;
    end
    check("wait_valid_tmo", CW'(fc_TVALID), CW'(1));
  endtask

  task automatic finish_frame(input int exp_done);
    int t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(negedge ap_clk);
      t++;
    end
    check("beats_tmo", CW'(sb.size()), CW'(0));
    @(negedge ap_clk);
    check("wait_busy", CW'(busy), CW'(1));
    check("wait_no_done", CW'(done), CW'(0));
    check("bias_valid", CW'(bias_valid), CW'(1));
    for (int k = 0; k < N_OUT; k++) begin
      check($sformatf("bias_word%0d", k), CW'(bias_data[k*W_W +: W_W]), CW'(exp_bias[k]));
    end
    label_done = 1'b1;
    @(negedge ap_clk);
    label_done = 1'b0;
    check("done_pulse", CW'(done), CW'(1));
    @(negedge ap_clk);
    check("done_clear", CW'(done), CW'(0));
    check("idle_busy", CW'(busy), CW'(0));
    check("bias_hold", CW'(bias_valid), CW'(1));
    check("done_count", CW'(done_cnt), CW'(exp_done));
  endtask

  initial begin : main
    int t;
    ap_rst = 1'b1;
    start = 1'b0;
    label_done = 1'b0;
    fc_TREADY = 1'b1;
    repeat (3) @(negedge ap_clk);
    check_zero("reset");
    ap_rst = 1'b0;

    // Clean frame with beat-spacing checks.
    spacing_en = 1'b1;
    load_frame(0);
    pulse_start();
    finish_frame(1);
    spacing_en = 1'b0;

    // Hold off the FC engine for five cycles on the first beat.
    fc_TREADY = 1'b0;
    load_frame(1);
    pulse_start();
    wait_valid();
    repeat (5) @(negedge ap_clk);
    fc_TREADY = 1'b1;
    finish_frame(2);

    // Gapped weight stream.
    w_toggle = 1'b1;
    load_frame(2);
    pulse_start();
    finish_frame(3);
    w_toggle = 1'b0;

    // Reset while gathering the second vector, then a clean frame.
    load_frame(3);
    pulse_start();
    t = 0;
    while (sb.size() != IN_LEN - 1 && t < 500) begin
      @(negedge ap_clk);
      t++;
    end
    check("rst_wait_tmo", CW'(sb.size()), CW'(IN_LEN - 1));
    repeat (2) @(negedge ap_clk);
    check("pre_rst_wgath", CW'({busy, fc_weight_TREADY, fc_TVALID}), CW'(3'b110));
    ap_rst = 1'b1;
    flush = 1'b1;
    @(posedge ap_clk); #2;
    sb.delete();
    @(negedge ap_clk);
    check_zero("midrst");
    ap_rst = 1'b0;
    flush = 1'b0;
    repeat (3) @(negedge ap_clk);
    check("midrst_no_done", CW'(done_cnt), CW'(3));
    load_frame(4);
    pulse_start();
    finish_frame(4);

    // start in ISSUE and label_done in WGATH are both ignored.
    load_frame(5);
    pulse_start();
    wait_valid();
    start = 1'b1;
    @(negedge ap_clk);
    start = 1'b0;
    t = 0;
    while (!(busy && bias_valid && fc_weight_TREADY && !fc_TVALID) && t < 500) begin
      @(negedge ap_clk);
      t++;
    end
    check("wgath_tmo", CW'(fc_weight_TREADY && !fc_TVALID), CW'(1));
    label_done = 1'b1;
    @(negedge ap_clk);
    label_done = 1'b0;
    check("spur_busy", CW'(busy), CW'(1));
    @(negedge ap_clk);
    check("spur_no_done", CW'(done), CW'(0));
    finish_frame(5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
